ed_stream_classifier: RTL and testbench

- Parametrised, pipelined successor to the combinational 3x3 edge classifier in the transmission-estimation path.
- Takes the 8 neighbour pixels of a 3x3 window (centre excluded) as a valid/ready stream and emits a 2-bit edge class plus the maximum directional gradient.
- Threshold is runtime-programmable and applied only at frame boundaries.
- Keeps per-frame diagonal and vertical/horizontal edge counts for downstream haze-estimation tuning.

---
 rtl/ed_pkg.sv | 26 ++
 rtl/ed_absdiff.sv | 20 ++
 rtl/ed_stream_classifier.sv | 179 +++++++++++++++++
 tb/tb_ed_stream_classifier.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ed_pkg.sv
// Shared edge-class codes, the class type and the default threshold
// for the 3x3 stream edge classifier.
package ed_pkg;

    typedef logic [1:0] ed_class_t;

    localparam ed_class_t ED_NONE = 2'd0;
    localparam ed_class_t ED_VH   = 2'd1;
    localparam ed_class_t ED_DIAG = 2'd2;

    localparam int unsigned ED_THRESHOLD_DEFAULT = 32'd80;

    // Diagonal wins over vertical/horizontal; code 3 is unreachable.
    function automatic ed_class_t ed_classify(input logic diag, input logic vh);
        ed_class_t cls;
        if (diag) begin
            cls = ED_DIAG;
        end else if (vh) begin
            cls = ED_VH;
        end else begin
            cls = ED_NONE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ed_absdiff.sv
// Unsigned absolute difference of two DATA_W-bit values; the result
// always fits in DATA_W bits.
module ed_absdiff #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] d
);

    // Subtract the smaller operand from the larger one.
    always_comb begin
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
    end

endmodule

// File: rtl/ed_stream_classifier.sv
// Two-stage valid/ready 3x3 edge classifier with frame-aligned threshold
// updates and saturating per-frame diagonal / vertical-horizontal counts.
module ed_stream_classifier
    import ed_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned THRESHOLD = ED_THRESHOLD_DEFAULT,
    parameter int unsigned CNT_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] p1,
    input  logic [DATA_W-1:0] p2,
    input  logic [DATA_W-1:0] p3,
    input  logic [DATA_W-1:0] p4,
    input  logic [DATA_W-1:0] p6,
    input  logic [DATA_W-1:0] p7,
    input  logic [DATA_W-1:0] p8,
    input  logic [DATA_W-1:0] p9,
    input  logic [DATA_W-1:0] thr_in,
    input  logic              thr_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        ed_out,
    output logic [DATA_W-1:0] grad_max,
    output logic              out_last,
    output logic              stat_valid,
    output logic [CNT_W-1:0]  stat_diag,
    output logic [CNT_W-1:0]  stat_vh
);

    localparam logic [DATA_W-1:0] THR_RST = DATA_W'(THRESHOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    logic              en_s;
    logic              accept_s;
    logic              hs_s;
    logic [DATA_W-1:0] d1_s, d2_s, dh_s, dv_s;

    logic              s1_valid_r, s1_last_r;
    logic [DATA_W-1:0] s1_d1_r, s1_d2_r, s1_dh_r, s1_dv_r, s1_thr_r;

    logic              diag_s, vh_s;
    ed_class_t         class_s;
    logic [DATA_W-1:0] max_a_s, max_b_s, grad_s;

    logic              out_valid_r, out_last_r;
    ed_class_t         ed_r;
    logic [DATA_W-1:0] grad_r;

    logic [DATA_W-1:0] shadow_thr_r, active_thr_r;

    logic [CNT_W-1:0]  live_diag_r, live_vh_r, diag_next_s, vh_next_s;
    logic              stat_valid_r;
    logic [CNT_W-1:0]  stat_diag_r, stat_vh_r;

    assign en_s     = !out_valid_r || out_ready;
    assign accept_s = in_valid && en_s;
    assign hs_s     = out_valid_r && out_ready;

    ed_absdiff #(.DATA_W(DATA_W)) u_abs_d1 (.a(p1), .b(p9), .d(d1_s));
    ed_absdiff #(.DATA_W(DATA_W)) u_abs_d2 (.a(p3), .b(p7), .d(d2_s));
    ed_absdiff #(.DATA_W(DATA_W)) u_abs_dh (.a(p4), .b(p6), .d(dh_s));
    ed_absdiff #(.DATA_W(DATA_W)) u_abs_dv (.a(p2), .b(p8), .d(dv_s));

    // Shadow takes every write; active follows it only when a frame's last
    // beat is accepted, so the threshold never changes inside a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_thr_r <= THR_RST;
            active_thr_r <= THR_RST;
        end else begin
            if (thr_we) begin
                shadow_thr_r <= thr_in;
            end
            if (accept_s && in_last) begin
                active_thr_r <= thr_we ? thr_in : shadow_thr_r;
            end
        end
    end

    // Stage 1: register the four gradients with the threshold in force.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_d1_r    <= '0;
            s1_d2_r    <= '0;
            s1_dh_r    <= '0;
            s1_dv_r    <= '0;
            s1_thr_r   <= THR_RST;
        end else if (en_s) begin
            s1_valid_r <= in_valid;
            s1_last_r  <= in_last;
            s1_d1_r    <= d1_s;
            s1_d2_r    <= d2_s;
            s1_dh_r    <= dh_s;
            s1_dv_r    <= dv_s;
            s1_thr_r   <= active_thr_r;
        end
    end

    // Stage 2 combinational classification and maximum gradient.
    always_comb begin
        diag_s  = (s1_d1_r >= s1_thr_r) || (s1_d2_r >= s1_thr_r);
        vh_s    = (s1_dh_r >= s1_thr_r) || (s1_dv_r >= s1_thr_r);
        class_s = ed_classify(diag_s, vh_s);
        max_a_s = (s1_d1_r >= s1_d2_r) ? s1_d1_r : s1_d2_r;
        max_b_s = (s1_dh_r >= s1_dv_r) ? s1_dh_r : s1_dv_r;
        grad_s  = (max_a_s >= max_b_s) ? max_a_s : max_b_s;
    end

    // Stage 2 output registers; they hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            ed_r        <= ED_NONE;
            grad_r      <= '0;
        end else if (en_s) begin
            out_valid_r <= s1_valid_r;
            out_last_r  <= s1_last_r;
            ed_r        <= class_s;
            grad_r      <= grad_s;
        end
    end

    // Saturating next values of the live counters for this handshake.
    always_comb begin
        diag_next_s = live_diag_r;
        vh_next_s   = live_vh_r;
        if (hs_s && (ed_r == ED_DIAG) && (live_diag_r != CNT_MAX)) begin
            diag_next_s = live_diag_r + CNT_ONE;
        end else begin
            diag_next_s = live_diag_r;
        end
        if (hs_s && (ed_r == ED_VH) && (live_vh_r != CNT_MAX)) begin
            vh_next_s = live_vh_r + CNT_ONE;
        end else begin
            vh_next_s = live_vh_r;
        end
    end

    // Frame statistics: publish on the last beat's handshake, then restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_diag_r  <= CNT_ZERO;
            live_vh_r    <= CNT_ZERO;
            stat_valid_r <= 1'b0;
            stat_diag_r  <= CNT_ZERO;
            stat_vh_r    <= CNT_ZERO;
        end else if (hs_s && out_last_r) begin
            live_diag_r  <= CNT_ZERO;
            live_vh_r    <= CNT_ZERO;
            stat_valid_r <= 1'b1;
            stat_diag_r  <= diag_next_s;
            stat_vh_r    <= vh_next_s;
        end else begin
            live_diag_r  <= diag_next_s;
            live_vh_r    <= vh_next_s;
            stat_valid_r <= 1'b0;
        end
    end

    assign in_ready   = en_s;
    assign out_valid  = out_valid_r;
    assign ed_out     = ed_r;
    assign grad_max   = grad_r;
    assign out_last   = out_last_r;
    assign stat_valid = stat_valid_r;
    assign stat_diag  = stat_diag_r;
    assign stat_vh    = stat_vh_r;

endmodule

// File: tb/tb_ed_stream_classifier.sv
// Directed bench for ed_stream_classifier: vector table, backpressure,
// frame-aligned threshold swap, statistics and mid-stream reset.
module tb_ed_stream_classifier;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_last, thr_we;
    logic        out_valid, out_ready, out_last, stat_valid;
    logic [7:0]  p1, p2, p3, p4, p6, p7, p8, p9, thr_in, grad_max;
    logic [1:0]  ed_out;
    logic [19:0] stat_diag, stat_vh;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [7:0] p1, p2, p3, p4, p6, p7, p8, p9;
        logic       last, we;
        logic [7:0] thr;
        logic [1:0] ed;
        logic [7:0] grad;
    } vec_t;

    vec_t tab[9];

    always #5 clk = ~clk;

    ed_stream_classifier #(.DATA_W(8), .THRESHOLD(80), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p6(p6),
        .p7(p7), .p8(p8), .p9(p9), .thr_in(thr_in), .thr_we(thr_we),
        .out_valid(out_valid), .out_ready(out_ready), .ed_out(ed_out),
        .grad_max(grad_max), .out_last(out_last), .stat_valid(stat_valid),
        .stat_diag(stat_diag), .stat_vh(stat_vh)
    );

    function automatic vec_t mk(string n, int a1, int a2, int a3, int a4, int a6,
                                int a7, int a8, int a9, int last, int we, int thr,
                                int ed, int grad);
        vec_t v;
        v.name = n;
        v.p1 = 8'(a1); v.p2 = 8'(a2); v.p3 = 8'(a3); v.p4 = 8'(a4);
        v.p6 = 8'(a6); v.p7 = 8'(a7); v.p8 = 8'(a8); v.p9 = 8'(a9);
        v.last = 1'(last); v.we = 1'(we); v.thr = 8'(thr);
        v.ed = 2'(ed); v.grad = 8'(grad);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_pix();
        p1 = 8'd0; p2 = 8'd0; p3 = 8'd0; p4 = 8'd0;
        p6 = 8'd0; p7 = 8'd0; p8 = 8'd0; p9 = 8'd0;
    endtask

    // Present one beat, confirm nothing emerges one cycle later, then check the result.
    task automatic send_vec(input vec_t v);
        @(negedge clk);
        p1 = v.p1; p2 = v.p2; p3 = v.p3; p4 = v.p4;
        p6 = v.p6; p7 = v.p7; p8 = v.p8; p9 = v.p9;
        in_last = v.last; thr_we = v.we; thr_in = v.thr;
        out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; thr_we = 1'b0; in_last = 1'b0;
        check({v.name, " early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        check({v.name, " ed_out"},    32'(ed_out),    32'(v.ed));
        check({v.name, " grad_max"},  32'(grad_max),  32'(v.grad));
        check({v.name, " out_last"},  32'(out_last),  32'(v.last));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; thr_we = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int         k, got, idx;
    int         exp_q[$];
    logic       stalled;
    logic [1:0] s_ed;
    logic [7:0] s_grad;
    logic       s_last;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; thr_we = 1'b0;
        thr_in = 8'd0; out_ready = 1'b1;
        clear_pix();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst out_valid",  32'(out_valid),  32'd0);
        check("rst stat_valid", 32'(stat_valid), 32'd0);
        check("rst stat_diag",  32'(stat_diag),  32'd0);
        check("rst stat_vh",    32'(stat_vh),    32'd0);
        check("rst ed_out",     32'(ed_out),     32'd0);
        check("rst grad_max",   32'(grad_max),   32'd0);
        check("rst out_last",   32'(out_last),   32'd0);
        check("rst in_ready",   32'(in_ready),   32'd1);

        // Table: threshold 80 boundary, priority, symmetry, ties.
        tab[0] = mk("thr_eq",    200,0,0,0,0,0,0,120,   0,0,0, 2, 80);
        tab[1] = mk("thr_below", 200,0,0,0,0,0,0,121,   0,0,0, 0, 79);
        tab[2] = mk("prio_diag", 0,255,0,0,0,90,0,0,    0,0,0, 2, 255);
        tab[3] = mk("vh_only",   0,255,0,0,0,0,0,0,     0,0,0, 1, 255);
        tab[4] = mk("dh_pos",    0,0,0,10,95,0,0,0,     0,0,0, 1, 85);
        tab[5] = mk("dh_neg",    0,0,0,95,10,0,0,0,     0,0,0, 1, 85);
        tab[6] = mk("flat",      100,100,100,100,100,100,100,100, 0,0,0, 0, 0);
        tab[7] = mk("both_diag", 0,0,255,0,0,0,0,255,   0,0,0, 2, 255);
        tab[8] = mk("dh_eq",     0,0,0,0,80,0,0,0,      0,0,0, 1, 80);
        for (int i = 0; i < 9; i++) send_vec(tab[i]);

        // Backpressure: 10 beats, out_ready pattern 1,0,0,1.
        do_reset();
        clear_pix();
        k = 0; got = 0; stalled = 1'b0;
        s_ed = 2'd0; s_grad = 8'd0; s_last = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            @(negedge clk);
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (k < 10) begin
                in_valid = 1'b1; p4 = 8'd0; p6 = 8'(k * 10 + 1); in_last = (k == 9);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            #1;
            check("bp in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (stalled) begin
                check("bp hold valid", 32'(out_valid), 32'd1);
                check("bp hold ed",    32'(ed_out),    32'(s_ed));
                check("bp hold grad",  32'(grad_max),  32'(s_grad));
                check("bp hold last",  32'(out_last),  32'(s_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp extra beat", 32'd1, 32'd0);
                end else begin
                    idx = exp_q.pop_front();
                    check("bp grad", 32'(grad_max), 32'(idx * 10 + 1));
                    check("bp ed",   32'(ed_out),   ((idx * 10 + 1) >= 80) ? 32'd1 : 32'd0);
                    check("bp last", 32'(out_last), 32'(idx == 9));
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            s_ed = ed_out; s_grad = grad_max; s_last = out_last;
            if (in_valid && in_ready) begin
                exp_q.push_back(k);
                k++;
            end
        end
        check("bp beats received", 32'(got), 32'd10);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;

        // Threshold swap only at frame boundary, including same-cycle write.
        do_reset();
        send_vec(mk("swap0", 60,0,0,0,0,0,0,0, 0,0,0,  0, 60));
        send_vec(mk("swap1", 60,0,0,0,0,0,0,0, 0,1,50, 0, 60));
        send_vec(mk("swap2", 60,0,0,0,0,0,0,0, 0,0,0,  0, 60));
        send_vec(mk("swap3", 60,0,0,0,0,0,0,0, 1,0,0,  0, 60));
        send_vec(mk("next0", 60,0,0,0,0,0,0,0, 0,0,0,  2, 60));
        send_vec(mk("next1", 40,0,0,0,0,0,0,0, 1,1,30, 0, 40));
        send_vec(mk("next2", 40,0,0,0,0,0,0,0, 0,0,0,  2, 40));

        // Statistics: 5 diagonal, 3 vh, 8 none, last on beat 15.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i < 5)      send_vec(mk("st_diag", 200,0,0,0,0,0,0,0, 0,0,0, 2, 200));
            else if (i < 8) send_vec(mk("st_vh",   0,200,0,0,0,0,0,0, 0,0,0, 1, 200));
            else            send_vec(mk("st_none", 0,0,0,0,0,0,0,0, (i == 15), 0,0, 0, 0));
            if (i == 14) check("st early pulse", 32'(stat_valid), 32'd0);
        end
        @(negedge clk);
        check("st pulse",   32'(stat_valid), 32'd1);
        check("st diag",    32'(stat_diag),  32'd5);
        check("st vh",      32'(stat_vh),    32'd3);
        @(negedge clk);
        check("st pulse end", 32'(stat_valid), 32'd0);
        check("st diag hold", 32'(stat_diag),  32'd5);
        send_vec(mk("st2_diag", 200,0,0,0,0,0,0,0, 0,0,0, 2, 200));
        send_vec(mk("st2_vh",   0,200,0,0,0,0,0,0, 1,0,0, 1, 200));
        @(negedge clk);
        check("st2 pulse", 32'(stat_valid), 32'd1);
        check("st2 diag",  32'(stat_diag),  32'd1);
        check("st2 vh",    32'(stat_vh),    32'd1);

        // Reset with beats in flight after threshold moved to 50.
        do_reset();
        send_vec(mk("pre_thr", 200,0,0,0,0,0,0,0, 1,1,50, 2, 200));
        send_vec(mk("pre_live", 200,0,0,0,0,0,0,0, 0,0,0, 2, 200));
        @(negedge clk);
        in_valid = 1'b1; p1 = 8'd200; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst out_valid",  32'(out_valid),  32'd0);
        check("mid_rst stat_valid", 32'(stat_valid), 32'd0);
        check("mid_rst stat_diag",  32'(stat_diag),  32'd0);
        check("mid_rst stat_vh",    32'(stat_vh),    32'd0);
        @(negedge clk);
        check("mid_rst no ghost", 32'(out_valid), 32'd0);
        send_vec(mk("post_thr80", 60,0,0,0,0,0,0,0, 0,0,0, 0, 60));
        send_vec(mk("post_vh",    0,200,0,0,0,0,0,0, 1,0,0, 1, 200));
        @(negedge clk);
        check("post pulse", 32'(stat_valid), 32'd1);
        check("post diag",  32'(stat_diag),  32'd0);
        check("post vh",    32'(stat_vh),    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
